// File: rtl/z80_bus_target.sv
// Slave end of the tv80s CPU bus: decodes memory, I/O and interrupt-acknowledge
// cycles and forwards them to one backing-store port, stretching with wait_n.
module z80_bus_target #(
  parameter int unsigned MEM_XWAIT  = 0,
  parameter int unsigned IO_XWAIT   = 1,
  parameter logic [7:0]  INT_VECTOR = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic        wait_n,
  output logic        bs_req,
  output logic        bs_io,
  output logic        bs_we,
  output logic [15:0] bs_addr,
  output logic [7:0]  bs_wdata,
  input  logic [7:0]  bs_rdata,
  input  logic        bs_ack,
  output logic        proto_err
);

  localparam logic [3:0] MEM_XW = 4'(MEM_XWAIT);
  localparam logic [3:0] IO_XW  = 4'(IO_XWAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_XWAIT,
    S_INTACK,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  di_q, di_d;
  logic        bs_io_q, bs_io_d;
  logic        bs_we_q, bs_we_d;
  logic [15:0] bs_addr_q, bs_addr_d;
  logic [7:0]  bs_wdata_q, bs_wdata_d;
  logic        proto_err_q, proto_err_d;
  logic [3:0]  xcnt_q, xcnt_d;

  logic        rw_strobe;
  logic        space_strobe;
  logic [3:0]  xwait_load;

  assign rw_strobe    = !rd_n || !wr_n;
  assign space_strobe = !mreq_n || !iorq_n;
  assign xwait_load   = bs_io_q ? IO_XW : MEM_XW;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      di_q        <= 8'h00;
      bs_io_q     <= 1'b0;
      bs_we_q     <= 1'b0;
      bs_addr_q   <= 16'h0000;
      bs_wdata_q  <= 8'h00;
      proto_err_q <= 1'b0;
      xcnt_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      di_q        <= di_d;
      bs_io_q     <= bs_io_d;
      bs_we_q     <= bs_we_d;
      bs_addr_q   <= bs_addr_d;
      bs_wdata_q  <= bs_wdata_d;
      proto_err_q <= proto_err_d;
      xcnt_q      <= xcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    di_d        = di_q;
    bs_io_d     = bs_io_q;
    bs_we_d     = bs_we_q;
    bs_addr_d   = bs_addr_q;
    bs_wdata_d  = bs_wdata_q;
    proto_err_d = proto_err_q;
    xcnt_d      = xcnt_q;
    case (state_q)
      S_IDLE: begin
        // Refresh wins outright so the post-fetch RFSH/MREQ never reaches the store.
        if (!rfsh_n) begin
          state_d = S_IDLE;
        end else if (!rd_n && !wr_n && space_strobe) begin
          proto_err_d = 1'b1;
        end else if ((!mreq_n && rw_strobe) || (!iorq_n && m1_n && rw_strobe)) begin
          state_d    = S_ACCESS;
          bs_io_d    = mreq_n;
          bs_we_d    = !wr_n;
          bs_addr_d  = A;
          bs_wdata_d = dout;
        end else if (!iorq_n && !m1_n) begin
          state_d = S_INTACK;
        end
      end
      S_ACCESS: begin
        if (bs_ack) begin
          if (!bs_we_q) begin
            di_d = bs_rdata;
          end
          xcnt_d  = xwait_load;
          state_d = (xwait_load == 4'd0) ? S_HOLD : S_XWAIT;
        end
      end
      S_XWAIT: begin
        if (xcnt_q <= 4'd1) begin
          xcnt_d  = 4'd0;
          state_d = S_HOLD;
        end else begin
          xcnt_d = xcnt_q - 4'd1;
        end
      end
      S_INTACK: begin
        di_d    = INT_VECTOR;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Wait for the strobe to drop so one CPU cycle yields one transaction.
        if (mreq_n && iorq_n) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wait_n = !((state_q == S_ACCESS) || (state_q == S_XWAIT));
    bs_req = (state_q == S_ACCESS);
  end

  assign di        = di_q;
  assign bs_io     = bs_io_q;
  assign bs_we     = bs_we_q;
  assign bs_addr   = bs_addr_q;
  assign bs_wdata  = bs_wdata_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_z80_bus_target.sv
// Directed bench for z80_bus_target: a store responder, a transaction/wait
// scoreboard and directed CPU bus cycles with hand-computed expectations.
module tb_z80_bus_target;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [7:0]  dout = 8'h00;
  logic [7:0]  di;
  logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
  logic        rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
  logic        wait_n, bs_req, bs_io, bs_we, proto_err;
  logic [15:0] bs_addr;
  logic [7:0]  bs_wdata;
  logic [7:0]  bs_rdata = 8'h00;
  logic        bs_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  z80_bus_target #(.MEM_XWAIT(0), .IO_XWAIT(1), .INT_VECTOR(8'hE0)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .dout(dout), .di(di),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .rfsh_n(rfsh_n), .wait_n(wait_n), .bs_req(bs_req), .bs_io(bs_io),
    .bs_we(bs_we), .bs_addr(bs_addr), .bs_wdata(bs_wdata),
    .bs_rdata(bs_rdata), .bs_ack(bs_ack), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing store: ack ack_lat negedges after bs_req is first seen.
  typedef struct {
    bit          io;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  txn_t        exp_txn[$];
  int          exp_wait[$];
  logic [7:0]  mem [logic [15:0]];
  int          ack_lat = 0;
  logic [7:0]  rdata_next = 8'h00;
  int          rcnt = 0;
  bit          rdone = 0;

  always @(negedge clk) begin
    bs_ack = 1'b0;
    if (!bs_req) begin
      rcnt  = 0;
      rdone = 0;
    end else if (!rdone) begin
      if (rcnt == ack_lat) begin
        bs_ack = 1'b1;
        if (!bs_io && mem.exists(bs_addr)) bs_rdata = mem[bs_addr];
        else bs_rdata = rdata_next;
        if (bs_we && !bs_io) mem[bs_addr] = bs_wdata;
        rdone = 1;
      end else begin
        rcnt++;
      end
    end
  end

  // Monitor: checks each new request and the length of each wait_n-low run.
  logic prev_req = 1'b0;
  int   wait_run = 0;

  always @(negedge clk) begin
    if (bs_req && !prev_req) begin
      if (exp_txn.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: addr %h with no request expected", bs_addr);
      end else begin
        txn_t t;
        t = exp_txn.pop_front();
        check("req_io", {15'd0, bs_io}, {15'd0, t.io});
        check("req_we", {15'd0, bs_we}, {15'd0, t.we});
        check("req_addr", bs_addr, t.addr);
        if (t.we) check("req_wdata", {8'd0, bs_wdata}, {8'd0, t.wdata});
      end
    end
    prev_req = bs_req;
    if (!wait_n) begin
      wait_run++;
    end else if (wait_run > 0) begin
      if (exp_wait.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wait: run of %0d clocks, none expected", wait_run);
      end else begin
        check("wait_len", 16'(wait_run), 16'(exp_wait.pop_front()));
      end
      wait_run = 0;
    end
  end

  task automatic release_bus();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  // Drive a cycle at a negedge, hold until wait_n is high (or release early),
  // then drop the strobes and let HOLD return to IDLE.
  task automatic bus_cycle(input bit m1, input bit mreq, input bit iorq, input bit rd,
                           input bit wr, input logic [15:0] addr, input logic [7:0] data,
                           input bit rel_early);
    int n;
    A = addr; dout = data;
    m1_n = m1; mreq_n = mreq; iorq_n = iorq; rd_n = rd; wr_n = wr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rel_early) release_bus();
    end while (!wait_n && n < 60);
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL cycle_timeout: wait_n still %b after %0d clocks", wait_n, n);
    end
    release_bus();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    release_bus();
    repeat (3) @(negedge clk);
    check("rst_di", {8'd0, di}, 16'h0000);
    check("rst_wait_n", {15'd0, wait_n}, 16'h0001);
    check("rst_bs_req", {15'd0, bs_req}, 16'h0000);
    check("rst_bs_io", {15'd0, bs_io}, 16'h0000);
    check("rst_bs_we", {15'd0, bs_we}, 16'h0000);
    check("rst_bs_addr", bs_addr, 16'h0000);
    check("rst_bs_wdata", {8'd0, bs_wdata}, 16'h0000);
    check("rst_proto_err", {15'd0, proto_err}, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);

    // Memory write, ack two clocks late: three wait clocks.
    ack_lat = 2;
    exp_txn.push_back('{io: 0, we: 1, addr: 16'hC9F7, wdata: 8'h49});
    exp_wait.push_back(3);
    bus_cycle(1, 0, 1, 1, 0, 16'hC9F7, 8'h49, 0);
    check("mem_C9F7", {8'd0, mem.exists(16'hC9F7) ? mem[16'hC9F7] : 8'hXX}, 16'h0049);
    check("write_keeps_di", {8'd0, di}, 16'h0000);

    // Opcode fetch with same-clock ack, followed by a refresh phase.
    ack_lat = 0; rdata_next = 8'hDE;
    exp_txn.push_back('{io: 0, we: 0, addr: 16'h0003, wdata: 8'h00});
    exp_wait.push_back(1);
    bus_cycle(0, 0, 1, 0, 1, 16'h0003, 8'h00, 0);
    check("fetch_di", {8'd0, di}, 16'h00DE);
    A = 16'h0004; mreq_n = 1'b0; rfsh_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rfsh_no_req", {15'd0, bs_req}, 16'h0000);
      check("rfsh_wait_n", {15'd0, wait_n}, 16'h0001);
    end
    release_bus();
    @(negedge clk);

    // I/O read, ack one clock late, plus one extra I/O wait clock.
    ack_lat = 1; rdata_next = 8'h5A;
    exp_txn.push_back('{io: 1, we: 0, addr: 16'h12FE, wdata: 8'h00});
    exp_wait.push_back(3);
    bus_cycle(1, 1, 0, 0, 1, 16'h12FE, 8'h00, 0);
    check("io_read_di", {8'd0, di}, 16'h005A);

    // I/O write with immediate ack: one ACCESS clock plus one XWAIT clock.
    ack_lat = 0;
    exp_txn.push_back('{io: 1, we: 1, addr: 16'h34AB, wdata: 8'h5C});
    exp_wait.push_back(2);
    bus_cycle(1, 1, 0, 1, 0, 16'h34AB, 8'h5C, 0);
    check("io_write_keeps_di", {8'd0, di}, 16'h005A);

    // IM2 acknowledge: vector on di, no store request, no wait.
    bus_cycle(0, 1, 0, 1, 1, 16'h0000, 8'h00, 0);
    check("intack_di", {8'd0, di}, 16'h00E0);
    check("intack_no_req", {15'd0, bs_req}, 16'h0000);

    // Strobe dropped mid-ACCESS: transaction still completes into di.
    ack_lat = 5; rdata_next = 8'h77;
    exp_txn.push_back('{io: 0, we: 0, addr: 16'h0100, wdata: 8'h00});
    exp_wait.push_back(6);
    bus_cycle(1, 0, 1, 0, 1, 16'h0100, 8'h00, 1);
    check("abandoned_read_di", {8'd0, di}, 16'h0077);

    // RD and WR both low under MREQ: sticky protocol error, no request.
    A = 16'h2222; mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (2) @(negedge clk);
    check("proto_err_set", {15'd0, proto_err}, 16'h0001);
    check("proto_wait_n", {15'd0, wait_n}, 16'h0001);
    release_bus();
    @(negedge clk);
    ack_lat = 0; rdata_next = 8'hDE;
    exp_txn.push_back('{io: 0, we: 0, addr: 16'h0003, wdata: 8'h00});
    exp_wait.push_back(1);
    bus_cycle(1, 0, 1, 0, 1, 16'h0003, 8'h00, 0);
    check("proto_err_sticky", {15'd0, proto_err}, 16'h0001);
    check("read_after_proto_di", {8'd0, di}, 16'h00DE);

    // Reset asserted while ACCESS is waiting on a slow store.
    ack_lat = 10;
    exp_txn.push_back('{io: 0, we: 0, addr: 16'h0200, wdata: 8'h00});
    exp_wait.push_back(2);
    A = 16'h0200; mreq_n = 1'b0; rd_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_bs_req", {15'd0, bs_req}, 16'h0000);
    check("arst_wait_n", {15'd0, wait_n}, 16'h0001);
    check("arst_di", {8'd0, di}, 16'h0000);
    check("arst_proto_err", {15'd0, proto_err}, 16'h0000);
    check("arst_bs_addr", bs_addr, 16'h0000);
    release_bus();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Back in IDLE: read the byte written earlier.
    ack_lat = 0; rdata_next = 8'h00;
    exp_txn.push_back('{io: 0, we: 0, addr: 16'hC9F7, wdata: 8'h00});
    exp_wait.push_back(1);
    bus_cycle(1, 0, 1, 0, 1, 16'hC9F7, 8'h00, 0);
    check("readback_di", {8'd0, di}, 16'h0049);

    repeat (2) @(negedge clk);
    check("txn_queue_empty", 16'(exp_txn.size()), 16'h0000);
    check("wait_queue_empty", 16'(exp_wait.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
